// File: rtl/spi_master_pkg.sv
// Shared definitions for the OPB SPI initiator: register offsets, field positions, FSM states.
package spi_master_pkg;

    localparam int LEN_W = 5;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_CLKDIV = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_CS_SEL  = 0;
    localparam int CTRL_CS_HOLD = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_LEN_LSB = 8;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_WCOL = 2;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

endpackage

// File: rtl/opb_spi_master_half_tick.sv
// Half-period timer: one-cycle tick after every D+1 enabled cycles, restarting whenever enable is low.
module spi_half_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 OPB_CLK,
    input  logic                 OPB_RST,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;

    assign tick = en && (cnt == div);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + DIV_WIDTH'(1);
    end

endmodule

// File: rtl/opb_spi_master.sv
// OPB-mapped mode-0 SPI initiator for the two APP FPGA SPI buses (shared SCLK), up to 32 bits per transfer.
module opb_spi_master
    import spi_master_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  OPB_CLK,
    input  logic                  OPB_RST,
    input  logic [DATA_WIDTH-1:0] OPB_DI,
    output logic [DATA_WIDTH-1:0] OPB_DO,
    input  logic [31:0]           OPB_ADDR,
    input  logic                  SPI_RE,
    input  logic                  SPI_WE,
    output logic                  SPI_IRQ,
    output logic                  APP_FPGA_SPI_CLK,
    output logic                  APP_FPGA_SPI0_CS_N,
    output logic                  APP_FPGA_SPI1_CS_N,
    output logic                  APP_FPGA_SPI0_MOSI,
    output logic                  APP_FPGA_SPI1_MOSI,
    input  logic                  APP_FPGA_SPI0_MISO,
    input  logic                  APP_FPGA_SPI1_MISO
);

    state_t                state, state_nxt;
    logic [1:0]            reg_sel;
    logic                  wr, busy, start, tick, finish, miso, cs_act, mosi_bit;
    logic                  ctrl_sel, ctrl_hold, ctrl_irq, w_sel, w_hold;
    logic [LEN_W-1:0]      ctrl_len, bit_idx;
    logic [DIV_WIDTH-1:0]  clkdiv, w_div;
    logic [DATA_WIDTH-1:0] tx_sr, rx_sr, rd_data;
    logic                  last_bit, done, wcol, cs_held;
    logic                  unused_addr;

    assign reg_sel     = OPB_ADDR[3:2];
    assign unused_addr = ^{OPB_ADDR[31:4], OPB_ADDR[1:0]};
    // A simultaneous read wins; the write is dropped.
    assign wr     = SPI_WE && !SPI_RE;
    assign busy   = (state != IDLE);
    assign start  = wr && (reg_sel == ADDR_DATA) && !busy;
    assign finish = (state == HOLD) && tick;
    assign miso   = w_sel ? APP_FPGA_SPI1_MISO : APP_FPGA_SPI0_MISO;

    spi_half_tick #(.DIV_WIDTH(DIV_WIDTH)) u_half_tick (
        .OPB_CLK (OPB_CLK),
        .OPB_RST (OPB_RST),
        .en      (busy),
        .div     (w_div),
        .tick    (tick)
    );

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   if (tick)  state_nxt = HIGH;
            HIGH:    if (tick)  state_nxt = LOW;
            LOW:     if (tick)  state_nxt = last_bit ? HOLD : HIGH;
            HOLD:    if (tick)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            ADDR_CTRL: begin
                rd_data[CTRL_CS_SEL]               = ctrl_sel;
                rd_data[CTRL_CS_HOLD]              = ctrl_hold;
                rd_data[CTRL_IRQ_EN]               = ctrl_irq;
                rd_data[CTRL_LEN_LSB +: LEN_W]     = ctrl_len;
            end
            ADDR_CLKDIV: rd_data[DIV_WIDTH-1:0] = clkdiv;
            ADDR_DATA:   rd_data = rx_sr;
            default: begin
                rd_data[STAT_BUSY] = busy;
                rd_data[STAT_DONE] = done;
                rd_data[STAT_WCOL] = wcol;
            end
        endcase
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            ctrl_sel <= 1'b0; ctrl_hold <= 1'b0; ctrl_irq <= 1'b0; ctrl_len <= '0;
            clkdiv   <= '0;   w_sel     <= 1'b0; w_hold   <= 1'b0; w_div    <= '0;
            tx_sr    <= '0;   rx_sr     <= '0;   bit_idx  <= '0;   last_bit <= 1'b0;
            done     <= 1'b0; wcol      <= 1'b0; cs_held  <= 1'b0; OPB_DO   <= '0;
        end else begin
            if (wr && reg_sel == ADDR_CTRL) begin
                ctrl_sel  <= OPB_DI[CTRL_CS_SEL];
                ctrl_hold <= OPB_DI[CTRL_CS_HOLD];
                ctrl_irq  <= OPB_DI[CTRL_IRQ_EN];
                ctrl_len  <= OPB_DI[CTRL_LEN_LSB +: LEN_W];
                if (!busy && !OPB_DI[CTRL_CS_HOLD]) cs_held <= 1'b0;
            end
            if (wr && reg_sel == ADDR_CLKDIV) clkdiv <= OPB_DI[DIV_WIDTH-1:0];
            if (wr && reg_sel == ADDR_STATUS && OPB_DI[STAT_WCOL]) wcol <= 1'b0;
            if (wr && reg_sel == ADDR_DATA && busy) wcol <= 1'b1;
            // The running transfer works only from the snapshot taken here.
            if (start) begin
                w_sel    <= ctrl_sel;
                w_hold   <= ctrl_hold;
                w_div    <= clkdiv;
                tx_sr    <= OPB_DI;
                rx_sr    <= '0;
                bit_idx  <= ctrl_len;
                last_bit <= 1'b0;
                done     <= 1'b0;
            end
            if (state == HIGH && tick) begin
                rx_sr <= {rx_sr[DATA_WIDTH-2:0], miso};
                if (bit_idx == '0) last_bit <= 1'b1;
                else               bit_idx  <= bit_idx - LEN_W'(1);
            end
            if (SPI_RE && reg_sel == ADDR_DATA) done <= 1'b0;
            if (finish) begin
                done    <= 1'b1;
                cs_held <= w_hold;
            end
            if (SPI_RE) OPB_DO <= rd_data;
        end
    end

    assign cs_act             = busy || cs_held;
    assign mosi_bit           = busy && tx_sr[bit_idx];
    assign APP_FPGA_SPI_CLK   = (state == HIGH);
    assign APP_FPGA_SPI0_CS_N = !(cs_act && !w_sel);
    assign APP_FPGA_SPI1_CS_N = !(cs_act && w_sel);
    assign APP_FPGA_SPI0_MOSI = mosi_bit && !w_sel;
    assign APP_FPGA_SPI1_MOSI = mosi_bit && w_sel;
    assign SPI_IRQ            = done && ctrl_irq;

endmodule

// File: tb/tb_opb_spi_master.sv
// Self-checking bench for opb_spi_master: register and transfer tables, random transfers vs. a waveform model, corner sequences.
module tb_opb_spi_master;

    logic        OPB_CLK = 1'b0;
    logic        OPB_RST;
    logic [31:0] OPB_DI, OPB_DO, OPB_ADDR;
    logic        SPI_RE, SPI_WE, SPI_IRQ;
    logic        APP_FPGA_SPI_CLK, APP_FPGA_SPI0_CS_N, APP_FPGA_SPI1_CS_N;
    logic        APP_FPGA_SPI0_MOSI, APP_FPGA_SPI1_MOSI;
    logic        APP_FPGA_SPI0_MISO, APP_FPGA_SPI1_MISO;

    int errors = 0;
    int checks = 0;

    // Responder: presents resp_word MSB-first from bit resp_len, advancing on each SCLK falling edge.
    logic [31:0] resp_word = '0;
    int          resp_len  = 0;
    int          resp_base = 0;
    int          sclk_falls = 0;
    int          sclk_rises = 0;
    int          resp_idx;
    logic        resp_bit, tb_sel = 1'b0, loop_mode = 1'b0;
    logic        hold_watch = 1'b0;
    int          hold_glitch = 0;

    always #5 OPB_CLK = ~OPB_CLK;
    always @(negedge APP_FPGA_SPI_CLK) sclk_falls++;
    always @(posedge APP_FPGA_SPI_CLK) sclk_rises++;
    always @(negedge OPB_CLK) if (hold_watch && APP_FPGA_SPI0_CS_N) hold_glitch++;

    assign resp_idx = resp_len - (sclk_falls - resp_base);
    assign resp_bit = (resp_idx >= 0 && resp_idx < 32) ? resp_word[resp_idx[4:0]] : 1'b0;
    assign APP_FPGA_SPI0_MISO = loop_mode ? APP_FPGA_SPI0_MOSI : (tb_sel ? ~resp_bit : resp_bit);
    assign APP_FPGA_SPI1_MISO = tb_sel ? resp_bit : ~resp_bit;

    opb_spi_master dut (
        .OPB_CLK            (OPB_CLK),
        .OPB_RST            (OPB_RST),
        .OPB_DI             (OPB_DI),
        .OPB_DO             (OPB_DO),
        .OPB_ADDR           (OPB_ADDR),
        .SPI_RE             (SPI_RE),
        .SPI_WE             (SPI_WE),
        .SPI_IRQ            (SPI_IRQ),
        .APP_FPGA_SPI_CLK   (APP_FPGA_SPI_CLK),
        .APP_FPGA_SPI0_CS_N (APP_FPGA_SPI0_CS_N),
        .APP_FPGA_SPI1_CS_N (APP_FPGA_SPI1_CS_N),
        .APP_FPGA_SPI0_MOSI (APP_FPGA_SPI0_MOSI),
        .APP_FPGA_SPI1_MOSI (APP_FPGA_SPI1_MOSI),
        .APP_FPGA_SPI0_MISO (APP_FPGA_SPI0_MISO),
        .APP_FPGA_SPI1_MISO (APP_FPGA_SPI1_MISO)
    );

    localparam logic [31:0] A_CTRL = 32'h0, A_DIV = 32'h4, A_DATA = 32'h8, A_STAT = 32'hC;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] div;
        logic [31:0] data;
        logic [31:0] resp;
        logic        loop;
        logic [31:0] exp_rx;
    } xfer_vec_t;

    reg_vec_t  reg_tab[6];
    xfer_vec_t xfer_tab[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic opb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge OPB_CLK);
        OPB_ADDR = addr; OPB_DI = data; SPI_WE = 1'b1;
        @(negedge OPB_CLK);
        SPI_WE = 1'b0;
    endtask

    task automatic opb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge OPB_CLK);
        OPB_ADDR = addr; SPI_RE = 1'b1;
        @(negedge OPB_CLK);
        SPI_RE = 1'b0;
        data = OPB_DO;
    endtask

    task automatic wait_idle(output logic [31:0] status);
        int polls = 0;
        opb_read(A_STAT, status);
        while (status[0] && polls < 300) begin
            opb_read(A_STAT, status);
            polls++;
        end
        check("idle_wait_busy", {31'b0, status[0]}, 32'h0);
    endtask

    function automatic logic [31:0] len_mask(input int len);
        return (len >= 31) ? 32'hFFFF_FFFF : ((32'h1 << (len + 1)) - 32'h1);
    endfunction

    // Expected pins per cycle: phase p = cycle/H; odd phases below 2N are SCLK high;
    // MOSI carries bit len - p/2 through phase 2N-1 (last HIGH).
    task automatic run_transfer(input logic [31:0] ctrl, input logic [31:0] div, input logic [31:0] data,
                                input logic [31:0] resp, input logic loop, input logic [31:0] exp_rx);
        int len, n, h, b, phase, bad, first_bad;
        logic sel, hold, irq, exp_sclk, cs_s, cs_o, mosi_s, mosi_o;
        logic [31:0] rd;
        len = int'(ctrl[12:8]); n = len + 1; h = int'(div[15:0]) + 1; b = (2 * n + 2) * h;
        sel = ctrl[0]; hold = ctrl[1]; irq = ctrl[2];
        bad = 0; first_bad = -1;
        opb_write(A_DIV, div);
        opb_write(A_CTRL, ctrl);
        tb_sel = sel; loop_mode = loop; resp_word = resp; resp_len = len; resp_base = sclk_falls;
        opb_write(A_DATA, data);
        for (int i = 0; i < b; i++) begin
            phase    = i / h;
            exp_sclk = (phase % 2 == 1) && (phase < 2 * n);
            cs_s   = sel ? APP_FPGA_SPI1_CS_N : APP_FPGA_SPI0_CS_N;
            cs_o   = sel ? APP_FPGA_SPI0_CS_N : APP_FPGA_SPI1_CS_N;
            mosi_s = sel ? APP_FPGA_SPI1_MOSI : APP_FPGA_SPI0_MOSI;
            mosi_o = sel ? APP_FPGA_SPI0_MOSI : APP_FPGA_SPI1_MOSI;
            if (APP_FPGA_SPI_CLK !== exp_sclk || cs_s !== 1'b0 || cs_o !== 1'b1 || mosi_o !== 1'b0 ||
                (phase <= 2 * n - 1 && mosi_s !== data[len - phase / 2])) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            @(negedge OPB_CLK);
        end
        if (bad != 0) $display("  first waveform deviation at cycle %0d of %0d", first_bad, b);
        check("xfer_wave_bad_cycles", bad, 0);
        check("xfer_cs_after", {31'b0, sel ? APP_FPGA_SPI1_CS_N : APP_FPGA_SPI0_CS_N}, {31'b0, !hold});
        check("xfer_irq", {31'b0, SPI_IRQ}, {31'b0, irq});
        opb_read(A_STAT, rd);
        check("xfer_status_done", rd, 32'h2);
        opb_read(A_DATA, rd);
        check("xfer_rx", rd, exp_rx);
        opb_read(A_STAT, rd);
        check("xfer_status_cleared", rd, 32'h0);
        check("xfer_irq_cleared", {31'b0, SPI_IRQ}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, d, c;
        int len, guard, base;

        reg_tab[0] = '{A_CTRL,        32'hFFFF_FFFF, 32'h0000_1F07};
        reg_tab[1] = '{A_DIV,         32'hFFFF_FFFF, 32'h0000_FFFF};
        reg_tab[2] = '{A_CTRL,        32'h0000_0A05, 32'h0000_0A05};
        reg_tab[3] = '{32'h1230_0005, 32'h0001_2345, 32'h0000_2345};
        reg_tab[4] = '{A_STAT,        32'hFFFF_FFFF, 32'h0000_0000};
        reg_tab[5] = '{32'hFF00_0003, 32'h0000_0000, 32'h0000_0000};

        xfer_tab[0] = '{32'h0704, 32'd0, 32'h0000_00A5, 32'h0,         1'b1, 32'h0000_00A5};
        xfer_tab[1] = '{32'h1F01, 32'd3, 32'h0F0F_1234, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        xfer_tab[2] = '{32'h0000, 32'd2, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0001};
        xfer_tab[3] = '{32'h0305, 32'd0, 32'h0000_0009, 32'h0000_000C, 1'b0, 32'h0000_000C};
        xfer_tab[4] = '{32'h0F00, 32'd1, 32'h0000_BEEF, 32'h0,         1'b1, 32'h0000_BEEF};

        // Reset held while every input toggles randomly.
        OPB_RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge OPB_CLK);
            OPB_DI = $urandom; OPB_ADDR = $urandom; SPI_RE = 1'($urandom); SPI_WE = 1'($urandom);
            resp_word = $urandom; tb_sel = 1'($urandom);
        end
        @(negedge OPB_CLK);
        check("rst_sclk", {31'b0, APP_FPGA_SPI_CLK}, 32'h0);
        check("rst_cs_n", {30'b0, APP_FPGA_SPI1_CS_N, APP_FPGA_SPI0_CS_N}, 32'h3);
        check("rst_mosi", {30'b0, APP_FPGA_SPI1_MOSI, APP_FPGA_SPI0_MOSI}, 32'h0);
        check("rst_opb_do", OPB_DO, 32'h0);
        check("rst_irq", {31'b0, SPI_IRQ}, 32'h0);
        SPI_RE = 1'b0; SPI_WE = 1'b0; OPB_DI = '0; OPB_ADDR = '0;
        OPB_RST = 1'b0;
        opb_read(A_STAT, rd);
        check("rst_status", rd, 32'h0);
        opb_read(A_CTRL, rd);
        check("rst_ctrl", rd, 32'h0);

        foreach (reg_tab[i]) begin
            opb_write(reg_tab[i].addr, reg_tab[i].wdata);
            opb_read(reg_tab[i].addr, rd);
            check($sformatf("reg_tab[%0d]", i), rd, reg_tab[i].exp);
        end

        foreach (xfer_tab[i])
            run_transfer(xfer_tab[i].ctrl, xfer_tab[i].div, xfer_tab[i].data,
                         xfer_tab[i].resp, xfer_tab[i].loop, xfer_tab[i].exp_rx);

        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(0, 31);
            c = {19'b0, 5'(len), 5'b0, 1'($urandom), 1'b0, 1'($urandom)};
            rd = $urandom;
            run_transfer(c, 32'($urandom_range(0, 3)), $urandom, rd, 1'b0, rd & len_mask(len));
        end

        // DATA write during a running transfer: flagged, ignored.
        tb_sel = 1'b0; loop_mode = 1'b0; resp_word = 32'h5A; resp_len = 7; resp_base = sclk_falls;
        opb_write(A_DIV, 32'd1);
        opb_write(A_CTRL, 32'h0700);
        base = sclk_rises;
        opb_write(A_DATA, 32'h3C);
        guard = 0;
        while (sclk_rises - base < 5 && guard < 100) begin @(negedge OPB_CLK); guard++; end
        check("wcol_reach_bit3", sclk_rises - base, 5);
        opb_write(A_DATA, 32'hFF);
        wait_idle(rd);
        check("wcol_status", rd, 32'h6);
        check("wcol_pulses", sclk_rises - base, 8);
        opb_read(A_DATA, rd);
        check("wcol_rx", rd, 32'h5A);
        opb_write(A_STAT, 32'h4);
        opb_read(A_STAT, rd);
        check("wcol_cleared", rd, 32'h0);

        // Held chip select across two back-to-back transfers, released by a CTRL write.
        run_transfer(32'h0702, 32'd0, 32'h11, 32'h3E, 1'b0, 32'h3E);
        hold_watch = 1'b1;
        run_transfer(32'h0702, 32'd0, 32'h22, 32'hC1, 1'b0, 32'hC1);
        hold_watch = 1'b0;
        check("hold_glitches", hold_glitch, 0);
        opb_write(A_CTRL, 32'h0700);
        check("hold_release", {31'b0, APP_FPGA_SPI0_CS_N}, 32'h1);

        // Asynchronous reset in the HIGH phase of bit 5.
        opb_write(A_DIV, 32'd1);
        opb_write(A_CTRL, 32'h0704);
        opb_read(A_DIV, rd);
        check("prereset_opb_do", rd, 32'h1);
        base = sclk_rises;
        opb_write(A_DATA, 32'hFF);
        guard = 0;
        while (!(sclk_rises - base == 3 && APP_FPGA_SPI_CLK) && guard < 100) begin
            @(negedge OPB_CLK); guard++;
        end
        check("midrst_reach_bit5", {31'b0, APP_FPGA_SPI_CLK}, 32'h1);
        OPB_RST = 1'b1;
        #1;
        check("midrst_sclk", {31'b0, APP_FPGA_SPI_CLK}, 32'h0);
        check("midrst_cs_n", {30'b0, APP_FPGA_SPI1_CS_N, APP_FPGA_SPI0_CS_N}, 32'h3);
        check("midrst_mosi", {30'b0, APP_FPGA_SPI1_MOSI, APP_FPGA_SPI0_MOSI}, 32'h0);
        check("midrst_opb_do", OPB_DO, 32'h0);
        check("midrst_irq", {31'b0, SPI_IRQ}, 32'h0);
        @(negedge OPB_CLK);
        OPB_RST = 1'b0;
        opb_read(A_STAT, rd);
        check("midrst_status", rd, 32'h0);
        opb_read(A_DATA, rd);
        check("midrst_rx", rd, 32'h0);

        // Read and write strobes together: the read is served, the write dropped.
        opb_write(A_DIV, 32'd5);
        @(negedge OPB_CLK);
        OPB_ADDR = A_DIV; OPB_DI = 32'd9; SPI_RE = 1'b1; SPI_WE = 1'b1;
        @(negedge OPB_CLK);
        SPI_RE = 1'b0; SPI_WE = 1'b0;
        d = OPB_DO;
        check("collide_read", d, 32'd5);
        opb_read(A_DIV, rd);
        check("collide_write_dropped", rd, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
